// File: rtl/countdown_timer_if.sv
// Control/status bundle between a processor-side controller and the
// countdown_timer. The master drives the strobes and reload value; the
// timer (slave) drives the count and status flags.
interface countdown_timer_if #(
    parameter int N = 16
);
    logic         Tick;
    logic         Load;
    logic [N-1:0] Din;
    logic         Start;
    logic         Stop;
    logic         AutoReload;
    logic         Clear;
    logic [N-1:0] Q;
    logic         Busy;
    logic         Done;
    logic         Expired;

    modport master (
        output Tick, Load, Din, Start, Stop, AutoReload, Clear,
        input  Q, Busy, Done, Expired
    );

    modport slave (
        input  Tick, Load, Din, Start, Stop, AutoReload, Clear,
        output Q, Busy, Done, Expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Programmable down-counting interval timer. Counts prescaler ticks down
// from a reload value, reports expiry as a one-cycle Done pulse plus a
// sticky Expired flag, and can optionally auto-reload for periodic events.
module countdown_timer #(
    parameter int N = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    countdown_timer_if.slave  ctrl
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] One = N'(1);

    state_t       state_q,   state_d;
    logic [N-1:0] count_q,   count_d;
    logic [N-1:0] reload_q,  reload_d;
    logic         done_q,    done_d;
    logic         expired_q, expired_d;

    // Register file: all state and outputs, cleared asynchronously by reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    // Next-state logic. Strobe priority is Load > Stop > Start > Tick, so a
    // tick landing on any command is dropped. Clear is independent of the
    // command chain, but an expiry in the same cycle re-sets Expired.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        expired_d = ctrl.Clear ? 1'b0 : expired_q;

        if (ctrl.Load) begin
            reload_d = ctrl.Din;
            count_d  = ctrl.Din;
        end else if (ctrl.Stop) begin
            if (state_q == RUN) begin
                state_d = IDLE;
            end
        end else if (ctrl.Start) begin
            if (state_q == IDLE) begin
                if (count_q != '0) begin
                    state_d = RUN;
                end else if (reload_q != '0) begin
                    count_d = reload_q;
                    state_d = RUN;
                end else begin
                    done_d    = 1'b1;
                    expired_d = 1'b1;
                end
            end
        end else if (ctrl.Tick && (state_q == RUN)) begin
            if (count_q > One) begin
                count_d = count_q - One;
            end else if (count_q == One) begin
                done_d    = 1'b1;
                expired_d = 1'b1;
                if (ctrl.AutoReload && (reload_q != '0)) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign ctrl.Q       = count_q;
    assign ctrl.Busy    = (state_q == RUN);
    assign ctrl.Done    = done_q;
    assign ctrl.Expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a table of one-cycle vectors with
// hand-computed expected outputs, followed by an asynchronous reset sequence.
module tb_countdown_timer;

    localparam int N = 16;

    logic Clock;
    logic Reset_n;

    countdown_timer_if #(.N(N)) bus ();

    countdown_timer #(.N(N)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .ctrl    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic         tick;
        logic         load;
        logic [N-1:0] din;
        logic         start;
        logic         stop;
        logic         autoReload;
        logic         clear;
        logic [N-1:0] expQ;
        logic         expBusy;
        logic         expDone;
        logic         expExpired;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic addVec(input logic tk, input logic ld, input int din,
                          input logic st, input logic sp, input logic ar,
                          input logic cl, input int q, input logic b,
                          input logic d, input logic e);
        vec_t v;
        v.tick = tk; v.load = ld; v.din = N'(din); v.start = st; v.stop = sp;
        v.autoReload = ar; v.clear = cl; v.expQ = N'(q); v.expBusy = b;
        v.expDone = d; v.expExpired = e;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] q,
                               input logic b, input logic d, input logic e);
        checks++;
        if (bus.Q !== q) begin
            failures++;
            $display("[TB] FAIL %s Q: got %0d expected %0d", name, bus.Q, q);
        end
        checks++;
        if (bus.Busy !== b) begin
            failures++;
            $display("[TB] FAIL %s Busy: got %b expected %b", name, bus.Busy, b);
        end
        checks++;
        if (bus.Done !== d) begin
            failures++;
            $display("[TB] FAIL %s Done: got %b expected %b", name, bus.Done, d);
        end
        checks++;
        if (bus.Expired !== e) begin
            failures++;
            $display("[TB] FAIL %s Expired: got %b expected %b", name, bus.Expired, e);
        end
    endtask

    task automatic driveIdle();
        bus.Tick = 1'b0; bus.Load = 1'b0; bus.Din = '0; bus.Start = 1'b0;
        bus.Stop = 1'b0; bus.AutoReload = 1'b0; bus.Clear = 1'b0;
    endtask

    // Drive one vector for one clock edge, then sample 1 time unit later.
    task automatic applyStimulus(input vec_t v, input string name);
        bus.Tick = v.tick; bus.Load = v.load; bus.Din = v.din;
        bus.Start = v.start; bus.Stop = v.stop;
        bus.AutoReload = v.autoReload; bus.Clear = v.clear;
        @(posedge Clock);
        #1;
        checkOutput(name, v.expQ, v.expBusy, v.expDone, v.expExpired);
    endtask

    initial begin
        // tk ld din st sp ar cl |  Q  busy done exp
        // One-shot of 3, ticks spaced 4 cycles apart
        addVec(0,1,3,0,0,0,0, 3,0,0,0);
        addVec(0,0,0,1,0,0,0, 3,1,0,0);
        addVec(1,0,0,0,0,0,0, 2,1,0,0);
        addVec(0,0,0,0,0,0,0, 2,1,0,0);
        addVec(0,0,0,0,0,0,0, 2,1,0,0);
        addVec(0,0,0,0,0,0,0, 2,1,0,0);
        addVec(1,0,0,0,0,0,0, 1,1,0,0);
        addVec(0,0,0,0,0,0,0, 1,1,0,0);
        addVec(0,0,0,0,0,0,0, 1,1,0,0);
        addVec(0,0,0,0,0,0,0, 1,1,0,0);
        addVec(1,0,0,0,0,0,0, 0,0,1,1);
        addVec(0,0,0,0,0,0,0, 0,0,0,1);
        // Start with Q==0 and nonzero reload reloads; then stop, clear
        addVec(0,0,0,1,0,0,0, 3,1,0,1);
        addVec(0,0,0,0,1,0,0, 3,0,0,1);
        addVec(0,0,0,0,0,0,1, 3,0,0,0);
        // Auto-reload with period 2; a Start while running is ignored
        addVec(0,1,2,0,0,1,0, 2,0,0,0);
        addVec(0,0,0,1,0,1,0, 2,1,0,0);
        addVec(0,0,0,1,0,1,0, 2,1,0,0);
        addVec(1,0,0,0,0,1,0, 1,1,0,0);
        addVec(1,0,0,0,0,1,0, 2,1,1,1);
        addVec(1,0,0,0,0,1,0, 1,1,0,1);
        addVec(1,0,0,0,0,1,0, 2,1,1,1);
        addVec(1,0,0,0,0,1,0, 1,1,0,1);
        addVec(1,0,0,0,0,1,0, 2,1,1,1);
        addVec(0,0,0,0,0,1,0, 2,1,0,1);
        // Tick colliding with Load in RUN, Clear, Start+Stop, Tick in IDLE
        addVec(1,1,9,0,0,1,0, 9,1,0,1);
        addVec(0,0,0,0,0,0,1, 9,1,0,0);
        addVec(0,0,0,1,1,0,0, 9,0,0,0);
        addVec(1,0,0,0,0,0,0, 9,0,0,0);
        // Stop/resume: 5 running ticks in total
        addVec(0,1,5,0,0,0,0, 5,0,0,0);
        addVec(0,0,0,1,0,0,0, 5,1,0,0);
        addVec(1,0,0,0,0,0,0, 4,1,0,0);
        addVec(1,0,0,0,0,0,0, 3,1,0,0);
        addVec(0,0,0,0,1,0,0, 3,0,0,0);
        addVec(1,0,0,0,0,0,0, 3,0,0,0);
        addVec(1,0,0,0,0,0,0, 3,0,0,0);
        addVec(1,0,0,0,0,0,0, 3,0,0,0);
        addVec(0,0,0,1,0,0,0, 3,1,0,0);
        addVec(1,0,0,0,0,0,0, 2,1,0,0);
        addVec(1,0,0,0,0,0,0, 1,1,0,0);
        addVec(1,0,0,0,0,0,0, 0,0,1,1);
        addVec(0,0,0,0,0,0,0, 0,0,0,1);
        // Clear coinciding with expiry: set wins
        addVec(0,1,1,0,0,0,1, 1,0,0,0);
        addVec(0,0,0,1,0,0,0, 1,1,0,0);
        addVec(1,0,0,0,0,0,1, 0,0,1,1);
        addVec(0,0,0,0,0,0,0, 0,0,0,1);
        // Zero reload: Start expires immediately without running
        addVec(0,1,0,0,0,0,0, 0,0,0,1);
        addVec(0,0,0,0,0,0,1, 0,0,0,0);
        addVec(0,0,0,1,0,0,0, 0,0,1,1);
        addVec(0,0,0,0,0,0,0, 0,0,0,1);
        addVec(0,0,0,0,0,0,1, 0,0,0,0);
        addVec(0,0,0,1,0,0,0, 0,0,1,1);
        addVec(0,0,0,0,0,0,0, 0,0,0,1);
        // Lead-in to the reset test: running at 7 with Expired set
        addVec(0,1,7,0,0,0,0, 7,0,0,1);
        addVec(0,0,0,1,0,0,0, 7,1,0,1);

        driveIdle();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("reset_state", '0, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-count: outputs clear before any clock edge
        driveIdle();
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_reset", '0, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        Reset_n = 1'b1;
        bus.Tick = 1'b1;
        @(posedge Clock);
        #1;
        checkOutput("tick_after_reset", '0, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b1;
        bus.Tick  = 1'b0;
        @(posedge Clock);
        #1;
        checkOutput("start_zero_after_reset", '0, 1'b0, 1'b1, 1'b1);
        driveIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting interval timer that consumes the one-cycle terminal-count strobe of the prescaler counter as its `Tick` input. The processor loads a reload value and issues Start/Stop commands; the block decrements once per tick and reports expiry. Expiry is reported as a one-cycle `Done` pulse and a sticky `Expired` flag. Optional auto-reload provides periodic events with a period of `ReloadReg` ticks.

## Interface
- `N`, 16, width of count, reload register and `Din`
- `Clock` input 1: rising-edge clock
- `Reset_n` input 1: asynchronous, active-low reset
- `Tick` input 1: one-cycle count strobe from the prescaler, synchronous to `Clock`
- `Load` input 1: one-cycle strobe; `ReloadReg <= Din`, `Q <= Din`
- `Din` input N: reload value
- `Start` input 1: one-cycle strobe; begin or resume counting
- `Stop` input 1: one-cycle strobe; halt counting, `Q` held
- `AutoReload` input 1: level; reload on expiry and keep running
- `Clear` input 1: one-cycle strobe; clears `Expired`
- `Q` output N: current count
- `Busy` output 1: high in RUN
- `Done` output 1: one-cycle expiry pulse
- `Expired` output 1: sticky expiry flag

## Operation
- **Reset values:** `Q=0`, `ReloadReg=0`, state IDLE, `Busy=0`, `Done=0`, `Expired=0`.
- **States:** IDLE and RUN. `Busy` is 1 exactly when the state is RUN.
- **Priority per cycle:** `Load` > `Stop` > `Start` > `Tick`.
  - A `Tick` coinciding with `Load`, `Stop` or `Start` is discarded.
- **Load:** accepted in any state and does not change state. In RUN, counting continues from `Din`.
- **Start in IDLE:**
  - If `Q != 0`: go to RUN and resume from `Q`.
  - If `Q == 0` and `ReloadReg != 0`: `Q <= ReloadReg`, go to RUN.
  - If `Q == 0` and `ReloadReg == 0`: `Done` pulses, `Expired` sets, stay IDLE.
- **Start in RUN:** ignored.
- **Stop:** in RUN, go to IDLE with `Q` held; a later `Start` resumes from `Q`. In IDLE, no effect.
- **Tick in RUN, `Q > 1`:** `Q <= Q-1`.
- **Tick in RUN, `Q == 1` (expiry):**
  - `Done` pulses and `Expired` sets.
  - If `AutoReload=1` and `ReloadReg != 0`: `Q <= ReloadReg`, stay RUN. `Q` never shows 0 in this case.
  - Otherwise: `Q <= 0`, go to IDLE.
- **Tick in IDLE:** ignored.
- **Clear:** `Expired <= 0`. When `Clear` coincides with an expiry, the set wins and `Expired` stays 1.
- **Arithmetic:** unsigned, N bits. Decrement is never applied at `Q == 0`, so there is no wrap-around.
- **AutoReload** is sampled at the expiry edge only.
- **Reset mid-count:** immediately returns all registers to their reset values, independent of `Clock`.

## Timing
- All outputs are registered. Changes appear on the rising edge that samples the causing strobe.
- `Q` changes on the same edge that samples `Tick`/`Load`/`Start`.
- `Done` is high for exactly one cycle, on the edge that samples the expiring `Tick`, in the same cycle in which `Q` shows 0 or the reload value. Back-to-back ticks give non-overlapping pulses.
- `Busy` rises on the edge that samples `Start` and falls on the edge that samples `Stop` or a non-reloading expiry.
- **Period with auto-reload:** exactly `ReloadReg` ticks between `Done` pulses.
- **Latency:** a one-shot of value V asserts `Done` on the V-th sampled `Tick` after `Start`.
- Strobe inputs (`Load`, `Start`, `Stop`, `Clear`, `Tick`) are treated as one-cycle pulses. A strobe held high for multiple cycles acts once per cycle.

## Test plan
- **Reset:** Reset asserted mid-RUN with `Q=7` → all outputs 0 and state IDLE immediately; `Tick` is ignored afterwards.
- **One-shot:** `Load Din=3`, `Start`, then 3 ticks spaced 4 cycles apart → `Q` goes 3,2,1,0; `Done` is high for one cycle on the 3rd tick edge; `Busy` falls on the same edge; `Expired=1`.
- **Auto-reload:** `Load Din=2`, `AutoReload=1`, `Start`, then 6 ticks → `Done` on ticks 2, 4 and 6; `Q` sequence 2,1,2,1,2,1,2; `Busy` stays 1.
- **Stop/resume:** `Load 5`, `Start`, 2 ticks, `Stop`, 3 ticks, `Start`, 3 ticks → `Q` holds at 3 while stopped; `Done` on the final tick; total sampled-tick count while running is 5.
- **Collisions:**
  - `Tick` coinciding with `Load Din=9` in RUN → `Q=9`, no decrement.
  - `Start`+`Stop` in the same cycle in RUN → IDLE.
  - `Clear` on the expiry edge → `Expired` stays 1.
- **Zero reload:** `Load Din=0`, `Start` → `Done` pulses once, `Expired=1`, `Busy` stays 0; a following `Clear` → `Expired=0`.
